// File: rtl/lpgbt_ctrl_pkg.sv
// Shared types and helpers for the lpGBT uplink link controller.
package lpgbt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MGT_RST   = 3'd1,
        ST_MGT_WAIT  = 3'd2,
        ST_DP_RST    = 3'd3,
        ST_LOCK_WAIT = 3'd4,
        ST_STABLE    = 3'd5,
        ST_UP        = 3'd6,
        ST_FAILED    = 3'd7
    } state_e;

    localparam int unsigned DP_RST_CYCLES = 4;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned RTY_W         = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/lpgbt_uplink_link_ctrl_if.sv
// Link-side handshake and status bundle of the uplink link controller.
interface lpgbt_uplink_link_ctrl_if;

    logic        enable_i;
    logic        restart_i;
    logic        mgt_rdy_i;
    logic        uplinkrdy_i;
    logic        uplinkFEC_i;
    logic        mgt_reset_o;
    logic        datapath_reset_o;
    logic        link_up_o;
    logic        failed_o;
    logic [2:0]  state_o;
    logic [3:0]  retry_cnt_o;
    logic [15:0] relock_cnt_o;
    logic [15:0] fec_win_cnt_o;

    modport master (
        output enable_i, restart_i, mgt_rdy_i, uplinkrdy_i, uplinkFEC_i,
        input  mgt_reset_o, datapath_reset_o, link_up_o, failed_o,
        input  state_o, retry_cnt_o, relock_cnt_o, fec_win_cnt_o
    );

    modport slave (
        input  enable_i, restart_i, mgt_rdy_i, uplinkrdy_i, uplinkFEC_i,
        output mgt_reset_o, datapath_reset_o, link_up_o, failed_o,
        output state_o, retry_cnt_o, relock_cnt_o, fec_win_cnt_o
    );

endinterface

// File: rtl/lpgbt_fec_window_mon.sv
// FEC correction monitor: counts corrected frames per fixed window while the link is up.
module lpgbt_fec_window_mon
    import lpgbt_ctrl_pkg::*;
#(
    parameter int unsigned FEC_WINDOW = 4096,
    parameter int unsigned FEC_THRESH = 64
) (
    input  logic             clk40_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             fec_i,
    output logic [CNT_W-1:0] fec_win_cnt_o,
    output logic             thresh_c
);

    localparam int unsigned WIN_W = (FEC_WINDOW > 1) ? $clog2(FEC_WINDOW) : 1;

    logic [WIN_W-1:0] win_tmr_q, win_tmr_d;
    logic [CNT_W-1:0] fec_cnt_q, fec_cnt_d;
    logic [CNT_W-1:0] fec_win_q, fec_win_d;
    logic [CNT_W-1:0] fec_cnt_inc;

    // A pulse on the window's last cycle is folded into the captured value.
    always_comb begin
        fec_cnt_inc = fec_i ? sat_inc(fec_cnt_q) : fec_cnt_q;
        win_tmr_d   = '0;
        fec_cnt_d   = '0;
        fec_win_d   = fec_win_q;
        if (en_i) begin
            if (win_tmr_q == WIN_W'(FEC_WINDOW - 1)) begin
                fec_win_d = fec_cnt_inc;
            end else begin
                win_tmr_d = win_tmr_q + WIN_W'(1);
                fec_cnt_d = fec_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            win_tmr_q <= '0;
            fec_cnt_q <= '0;
            fec_win_q <= '0;
        end else begin
            win_tmr_q <= win_tmr_d;
            fec_cnt_q <= fec_cnt_d;
            fec_win_q <= fec_win_d;
        end
    end

    assign fec_win_cnt_o = fec_win_q;
    assign thresh_c      = (fec_cnt_q >= CNT_W'(FEC_THRESH));

endmodule

// File: rtl/lpgbt_uplink_link_ctrl.sv
// Bring-up and supervision sequencer for the lpGBT-FPGA uplink: MGT reset, datapath
// reset, lock qualification, FEC/lock-loss relock and bounded retries.
module lpgbt_uplink_link_ctrl
    import lpgbt_ctrl_pkg::*;
#(
    parameter int unsigned MGT_RST_CYCLES = 16,
    parameter int unsigned MGT_TIMEOUT    = 4000,
    parameter int unsigned LOCK_TIMEOUT   = 40000,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned FEC_WINDOW     = 4096,
    parameter int unsigned FEC_THRESH     = 64,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic                     clk40_i,
    input  logic                     rst_i,
    lpgbt_uplink_link_ctrl_if.slave  bus
);

    localparam int unsigned MAX_A   = (MGT_TIMEOUT > LOCK_TIMEOUT) ? MGT_TIMEOUT : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (MGT_RST_CYCLES > STABLE_CYCLES) ? MGT_RST_CYCLES : STABLE_CYCLES;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TMR_MAX = (MAX_C > DP_RST_CYCLES) ? MAX_C : DP_RST_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [RTY_W-1:0]  retry_q, retry_d, retry_inc;
    logic [CNT_W-1:0]  relock_q, relock_d;
    logic              mgt_reset_q, mgt_reset_d;
    logic              dp_reset_q, dp_reset_d;
    logic              link_up_q, link_up_d;
    logic              failed_q, failed_d;
    logic              fail_attempt;
    logic              force_entry;
    logic              mon_en;
    logic              fec_thresh;
    logic [CNT_W-1:0]  fec_win_cnt;

    assign mon_en    = (state_q == ST_UP);
    assign retry_inc = retry_q + RTY_W'(1);

    lpgbt_fec_window_mon #(
        .FEC_WINDOW (FEC_WINDOW),
        .FEC_THRESH (FEC_THRESH)
    ) u_fec_mon (
        .clk40_i       (clk40_i),
        .rst_i         (rst_i),
        .en_i          (mon_en),
        .fec_i         (bus.uplinkFEC_i),
        .fec_win_cnt_o (fec_win_cnt),
        .thresh_c      (fec_thresh)
    );

    // State, timer and event counter registers.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            relock_q    <= '0;
            mgt_reset_q <= 1'b1;
            dp_reset_q  <= 1'b1;
            link_up_q   <= 1'b0;
            failed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            relock_q    <= relock_d;
            mgt_reset_q <= mgt_reset_d;
            dp_reset_q  <= dp_reset_d;
            link_up_q   <= link_up_d;
            failed_q    <= failed_d;
        end
    end

    // Next state; restart re-enters MGT_RST even from MGT_RST, so entry is flagged explicitly.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TMR_W'(1);
        retry_d      = retry_q;
        relock_d     = relock_q;
        fail_attempt = 1'b0;
        force_entry  = 1'b0;
        if (!bus.enable_i) begin
            state_d = ST_IDLE;
        end else if (bus.restart_i) begin
            state_d     = ST_MGT_RST;
            retry_d     = '0;
            force_entry = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_MGT_RST;
                ST_MGT_RST: begin
                    if (timer_q == TMR_W'(MGT_RST_CYCLES - 1)) state_d = ST_MGT_WAIT;
                end
                ST_MGT_WAIT: begin
                    if (bus.mgt_rdy_i) state_d = ST_DP_RST;
                    else if (timer_q == TMR_W'(MGT_TIMEOUT - 1)) fail_attempt = 1'b1;
                end
                ST_DP_RST: begin
                    if (timer_q == TMR_W'(DP_RST_CYCLES - 1)) state_d = ST_LOCK_WAIT;
                end
                ST_LOCK_WAIT: begin
                    if (!bus.mgt_rdy_i) fail_attempt = 1'b1;
                    else if (bus.uplinkrdy_i) state_d = ST_STABLE;
                    else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) fail_attempt = 1'b1;
                end
                ST_STABLE: begin
                    if (!bus.uplinkrdy_i) begin
                        state_d = ST_LOCK_WAIT;
                    end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                        state_d = ST_UP;
                        retry_d = '0;
                    end
                end
                ST_UP: begin
                    if (!bus.mgt_rdy_i) begin
                        state_d  = ST_MGT_RST;
                        relock_d = sat_inc(relock_q);
                    end else if (!bus.uplinkrdy_i || fec_thresh) begin
                        state_d  = ST_DP_RST;
                        relock_d = sat_inc(relock_q);
                    end
                end
                ST_FAILED: state_d = ST_FAILED;
                default:   state_d = ST_IDLE;
            endcase
            if (fail_attempt) begin
                retry_d = retry_inc;
                state_d = (retry_inc == RTY_W'(MAX_RETRIES)) ? ST_FAILED : ST_MGT_RST;
            end
        end
        if (force_entry || (state_d != state_q)) timer_d = '0;
    end

    // Outputs decoded from the next state so they change together with state_o.
    always_comb begin
        mgt_reset_d = 1'b1;
        dp_reset_d  = 1'b1;
        link_up_d   = 1'b0;
        failed_d    = 1'b0;
        unique case (state_d)
            ST_MGT_WAIT, ST_DP_RST: mgt_reset_d = 1'b0;
            ST_LOCK_WAIT, ST_STABLE: begin
                mgt_reset_d = 1'b0;
                dp_reset_d  = 1'b0;
            end
            ST_UP: begin
                mgt_reset_d = 1'b0;
                dp_reset_d  = 1'b0;
                link_up_d   = 1'b1;
            end
            ST_FAILED: failed_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.mgt_reset_o      = mgt_reset_q;
    assign bus.datapath_reset_o = dp_reset_q;
    assign bus.link_up_o        = link_up_q;
    assign bus.failed_o         = failed_q;
    assign bus.state_o          = state_q;
    assign bus.retry_cnt_o      = retry_q;
    assign bus.relock_cnt_o     = relock_q;
    assign bus.fec_win_cnt_o    = fec_win_cnt;

endmodule
